// File: rtl/lt24_touch_sequencer.sv
// Periodic X/Y reader for the LT24 touch controller: drives the SPI master's
// register port through a fixed six-byte frame and publishes 12-bit coordinates.
module lt24_touch_sequencer #(
    parameter int unsigned SAMPLE_DIV = 500000,
    parameter int unsigned TIMEOUT    = 65535,
    parameter logic [7:0]  CMD_Y      = 8'h90,
    parameter logic [7:0]  CMD_X      = 8'hD0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        pen_irq_n,
    output logic        spi_select,
    output logic [2:0]  spi_mem_addr,
    output logic        spi_write_n,
    output logic        spi_read_n,
    output logic [15:0] spi_wdata,
    input  logic [15:0] spi_rdata,
    input  logic        spi_trdy,
    input  logic        spi_rrdy,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        valid,
    output logic        pen_down,
    output logic        busy,
    output logic        err
);

    typedef enum logic [3:0] {
        IDLE,
        CFG_SS,
        CFG_CTL,
        WAIT_TRDY,
        WR_TX,
        WAIT_RRDY,
        RD_RX,
        RELEASE,
        DONE
    } state_t;

    localparam logic [23:0] DIV_LAST = 24'(SAMPLE_DIV - 1);
    localparam logic [19:0] TO_LAST  = 20'(TIMEOUT - 1);

    state_t      state;
    state_t      next_state;
    logic [1:0]  phase;
    logic [1:0]  next_phase;
    logic [2:0]  b;
    logic [2:0]  next_b;
    logic [19:0] wait_cnt;
    logic [23:0] timer;
    logic        tick;
    logic        pen_meta;
    logic        aborted;
    logic        timeout_hit;
    logic [7:0]  rx1;
    logic [7:0]  rx2;
    logic [7:0]  rx4;
    logic [7:0]  rx5;
    logic [7:0]  tx_byte;

    logic        sel_d;
    logic        wr_n_d;
    logic        rd_n_d;
    logic [2:0]  addr_d;
    logic [15:0] wdata_d;

    logic        unused_rdata_hi;
    assign unused_rdata_hi = ^spi_rdata[15:8];

    assign tick = enable && (timer == DIV_LAST);

    // The second synchronizer stage stores the inverted pin so pen_down is a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pen_meta <= 1'b1;
            pen_down <= 1'b0;
        end else begin
            pen_meta <= pen_irq_n;
            pen_down <= ~pen_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= 24'd0;
        end else if (!enable || tick) begin
            timer <= 24'd0;
        end else begin
            timer <= timer + 24'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            phase <= 2'd0;
            b     <= 3'd0;
        end else begin
            state <= next_state;
            phase <= next_phase;
            b     <= next_b;
        end
    end

    // Access states run three phases: two strobe cycles, then one idle gap cycle.
    always_comb begin
        next_state  = state;
        next_phase  = 2'd0;
        next_b      = b;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                next_b = 3'd0;
                if (tick && pen_down && enable) begin
                    next_state = CFG_SS;
                end
            end
            CFG_SS, CFG_CTL, WR_TX, RD_RX, RELEASE: begin
                if (phase != 2'd2) begin
                    next_phase = phase + 2'd1;
                end else begin
                    case (state)
                        CFG_SS:  next_state = CFG_CTL;
                        CFG_CTL: next_state = WAIT_TRDY;
                        WR_TX:   next_state = WAIT_RRDY;
                        RD_RX: begin
                            if (b == 3'd5) begin
                                next_state = RELEASE;
                            end else begin
                                next_b     = b + 3'd1;
                                next_state = WAIT_TRDY;
                            end
                        end
                        default: next_state = aborted ? IDLE : DONE;
                    endcase
                end
            end
            WAIT_TRDY: begin
                if (spi_trdy) begin
                    next_state = WR_TX;
                end else if (wait_cnt == TO_LAST) begin
                    next_state  = RELEASE;
                    timeout_hit = 1'b1;
                end
            end
            WAIT_RRDY: begin
                if (spi_rrdy) begin
                    next_state = RD_RX;
                end else if (wait_cnt == TO_LAST) begin
                    next_state  = RELEASE;
                    timeout_hit = 1'b1;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        tx_byte = 8'h00;
        if (next_b == 3'd0) begin
            tx_byte = CMD_Y;
        end else if (next_b == 3'd3) begin
            tx_byte = CMD_X;
        end
    end

    // Bus signals are decoded from the upcoming state so they leave the chip registered.
    always_comb begin
        sel_d   = 1'b0;
        wr_n_d  = 1'b1;
        rd_n_d  = 1'b1;
        addr_d  = 3'd0;
        wdata_d = 16'h0000;
        if (next_phase != 2'd2) begin
            case (next_state)
                CFG_SS: begin
                    sel_d   = 1'b1;
                    wr_n_d  = 1'b0;
                    addr_d  = 3'd5;
                    wdata_d = 16'h0001;
                end
                CFG_CTL: begin
                    sel_d   = 1'b1;
                    wr_n_d  = 1'b0;
                    addr_d  = 3'd3;
                    wdata_d = 16'h0400;
                end
                WR_TX: begin
                    sel_d   = 1'b1;
                    wr_n_d  = 1'b0;
                    addr_d  = 3'd1;
                    wdata_d = {8'h00, tx_byte};
                end
                RD_RX: begin
                    sel_d  = 1'b1;
                    rd_n_d = 1'b0;
                    addr_d = 3'd0;
                end
                RELEASE: begin
                    sel_d   = 1'b1;
                    wr_n_d  = 1'b0;
                    addr_d  = 3'd3;
                    wdata_d = 16'h0000;
                end
                default: sel_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spi_select   <= 1'b0;
            spi_write_n  <= 1'b1;
            spi_read_n   <= 1'b1;
            spi_mem_addr <= 3'd0;
            spi_wdata    <= 16'h0000;
            busy         <= 1'b0;
            valid        <= 1'b0;
        end else begin
            spi_select   <= sel_d;
            spi_write_n  <= wr_n_d;
            spi_read_n   <= rd_n_d;
            spi_mem_addr <= addr_d;
            spi_wdata    <= wdata_d;
            busy         <= (next_state != IDLE);
            valid        <= (next_state == DONE);
        end
    end

    // Wait-state budget restarts whenever a wait state is entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= 20'd0;
        end else if ((state == WAIT_TRDY || state == WAIT_RRDY) && next_state == state) begin
            wait_cnt <= wait_cnt + 20'd1;
        end else begin
            wait_cnt <= 20'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx1 <= 8'h00;
            rx2 <= 8'h00;
            rx4 <= 8'h00;
            rx5 <= 8'h00;
        end else if (state == RD_RX && phase == 2'd1) begin
            case (b)
                3'd1:    rx1 <= spi_rdata[7:0];
                3'd2:    rx2 <= spi_rdata[7:0];
                3'd4:    rx4 <= spi_rdata[7:0];
                3'd5:    rx5 <= spi_rdata[7:0];
                default: rx1 <= rx1;
            endcase
        end
    end

    // A timed-out frame skips DONE so the previous coordinates stay published.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x       <= 12'h000;
            y       <= 12'h000;
            err     <= 1'b0;
            aborted <= 1'b0;
        end else begin
            if (state == IDLE && next_state == CFG_SS) begin
                aborted <= 1'b0;
            end else if (timeout_hit) begin
                aborted <= 1'b1;
            end
            if (next_state == DONE) begin
                y   <= {rx1[6:0], rx2[7:3]};
                x   <= {rx4[6:0], rx5[7:3]};
                err <= 1'b0;
            end else if (timeout_hit) begin
                err <= 1'b1;
            end
        end
    end

endmodule
